// File: rtl/matrix_mult_pkg.sv
// Shared types and constants for the matrix-multiply tile scheduler.
package matrix_mult_pkg;

  // Largest K or N tile count a single job may request.
  localparam int unsigned MAX_TILES = 16;

  // Field widths of a latched job; these follow the default buffer depths (256 words).
  localparam int unsigned TILE_W   = $clog2(MAX_TILES) + 1;
  localparam int unsigned I_ADDR_W = 8;
  localparam int unsigned W_ADDR_W = 8;
  localparam int unsigned O_ADDR_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StAdvance,
    StDone
  } sched_state_e;

  typedef struct packed {
    logic [TILE_W-1:0]   k_tiles;
    logic [TILE_W-1:0]   n_tiles;
    logic [I_ADDR_W-1:0] i_rows;
    logic [W_ADDR_W-1:0] w_base;
    logic [I_ADDR_W-1:0] i_base;
    logic [O_ADDR_W-1:0] o_base;
  } sched_job_struct;

endpackage

// File: rtl/mm_sched_addr_gen.sv
// Per-tile offset and accumulate-enable generation from the latched job and (k, n).
// All offsets wrap naturally at the buffer depth.
module mm_sched_addr_gen
  import matrix_mult_pkg::*;
#(
  parameter int unsigned ROW = 4
) (
  input  sched_job_struct     job_i,
  input  logic [TILE_W-1:0]   k_i,
  input  logic [TILE_W-1:0]   n_i,
  output logic [W_ADDR_W-1:0] w_offset_o,
  output logic [I_ADDR_W-1:0] i_offset_o,
  output logic [O_ADDR_W-1:0] psum_offset_o,
  output logic [O_ADDR_W-1:0] o_offset_o,
  output logic                accum_en_o
);

  // Tiles are walked k-fastest, so tile index is n*K + k; each weight tile is ROW words.
  always_comb begin
    w_offset_o    = W_ADDR_W'(32'(job_i.w_base)
                    + (32'(n_i) * 32'(job_i.k_tiles) + 32'(k_i)) * ROW);
    i_offset_o    = I_ADDR_W'(32'(job_i.i_base) + 32'(k_i) * 32'(job_i.i_rows));
    o_offset_o    = O_ADDR_W'(32'(job_i.o_base) + 32'(n_i) * 32'(job_i.i_rows));
    psum_offset_o = o_offset_o;
    // First K slice of each output column starts fresh; later slices accumulate.
    accum_en_o    = (k_i != '0);
  end

endmodule

// File: rtl/mm_tile_scheduler.sv
// Tiled matrix-multiply sequencer: turns one K x N job into single-tile wrapper runs.
// Optional watchdog on the per-tile wait, enabled by defining MM_SCHED_TIMEOUT_EN.
module mm_tile_scheduler #(
  parameter int unsigned ROW            = 4,
  parameter int unsigned COL            = 4,
  parameter int unsigned I_SIZE         = 256,
  parameter int unsigned W_SIZE         = 256,
  parameter int unsigned O_SIZE         = 256,
  parameter int unsigned MAX_TILES      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk_i,
  input  logic                          rst_async_i,
  input  logic                          job_valid_i,
  output logic                          job_ready_o,
  input  logic [$clog2(MAX_TILES):0]    job_k_tiles_i,
  input  logic [$clog2(MAX_TILES):0]    job_n_tiles_i,
  input  logic [$clog2(I_SIZE)-1:0]     job_i_rows_i,
  input  logic [$clog2(W_SIZE)-1:0]     job_w_base_i,
  input  logic [$clog2(I_SIZE)-1:0]     job_i_base_i,
  input  logic [$clog2(O_SIZE)-1:0]     job_o_base_i,
  input  logic                          abort_i,
  output logic                          mm_start_o,
  input  logic                          mm_done_i,
  output logic [$clog2(W_SIZE)-1:0]     mm_w_offset_o,
  output logic [$clog2(I_SIZE)-1:0]     mm_i_offset_o,
  output logic [$clog2(O_SIZE)-1:0]     mm_psum_offset_o,
  output logic [$clog2(O_SIZE)-1:0]     mm_o_offset_o,
  output logic [$clog2(I_SIZE)-1:0]     mm_i_rows_o,
  output logic                          mm_accum_en_o,
  output logic                          busy_o,
  output logic                          job_done_o,
  output logic                          err_o
);

  import matrix_mult_pkg::*;

  // The latched job struct is sized from the package; reject configurations it cannot hold.
  if ($clog2(I_SIZE) != I_ADDR_W || $clog2(W_SIZE) != W_ADDR_W || $clog2(O_SIZE) != O_ADDR_W
      || $clog2(MAX_TILES) + 1 != TILE_W || ROW == 0 || COL == 0 || TIMEOUT_CYCLES == 0)
  begin : g_bad_cfg
    $error("mm_tile_scheduler: parameters do not match matrix_mult_pkg widths");
  end

  sched_state_e      state_q, state_d;
  sched_job_struct   job_q, job_d;
  logic [TILE_W-1:0] k_q, k_d;
  logic [TILE_W-1:0] n_q, n_d;
  logic              err_q, err_d;
  logic              job_ok;
  logic              tmo_hit;

  // A job is runnable only if both tile counts are in 1..MAX_TILES.
  assign job_ok = (job_k_tiles_i != '0) && (job_n_tiles_i != '0)
                  && (32'(job_k_tiles_i) <= MAX_TILES) && (32'(job_n_tiles_i) <= MAX_TILES);

`ifdef MM_SCHED_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  // Last WAIT cycle before the count would reach the limit.
  assign tmo_hit = (32'(tmo_q) == TIMEOUT_CYCLES - 1);

  // Wait-cycle counter: cleared while issuing, counts while waiting.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == StIssue) begin
      tmo_d = '0;
    end else if (state_q == StWait) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state, job latch and tile-counter logic.
  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    k_d     = k_q;
    n_d     = n_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (job_valid_i) begin
          job_d.k_tiles = job_k_tiles_i;
          job_d.n_tiles = job_n_tiles_i;
          job_d.i_rows  = job_i_rows_i;
          job_d.w_base  = job_w_base_i;
          job_d.i_base  = job_i_base_i;
          job_d.o_base  = job_o_base_i;
          k_d           = '0;
          n_d           = '0;
          err_d         = ~job_ok;
          state_d       = job_ok ? StIssue : StDone;
        end
      end
      StIssue: begin
        // Any mm_done_i here belongs to a previous run and is ignored.
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        // Abort beats done; done beats a same-cycle timeout.
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (mm_done_i) begin
          state_d = StAdvance;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StAdvance: begin
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          if ((k_q + 1'b1) < job_q.k_tiles) begin
            k_d = k_q + 1'b1;
          end else begin
            k_d = '0;
            n_d = n_q + 1'b1;
          end
          state_d = (n_d < job_q.n_tiles) ? StIssue : StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, job and counter registers.
  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      state_q <= StIdle;
      job_q   <= '0;
      k_q     <= '0;
      n_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      k_q     <= k_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end

  mm_sched_addr_gen #(
    .ROW (ROW)
  ) u_addr_gen (
    .job_i         (job_q),
    .k_i           (k_q),
    .n_i           (n_q),
    .w_offset_o    (mm_w_offset_o),
    .i_offset_o    (mm_i_offset_o),
    .psum_offset_o (mm_psum_offset_o),
    .o_offset_o    (mm_o_offset_o),
    .accum_en_o    (mm_accum_en_o)
  );

  // Status and handshake outputs decoded straight from the state register.
  always_comb begin
    job_ready_o = (state_q == StIdle);
    mm_start_o  = (state_q == StIssue);
    busy_o      = (state_q != StIdle);
    job_done_o  = (state_q == StDone);
    err_o       = err_q;
    mm_i_rows_o = job_q.i_rows;
  end

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// Randomized self-checking bench for mm_tile_scheduler against a tile-list/timeline model.
module tb_mm_tile_scheduler;

  localparam int unsigned ROW   = 4;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned TMO   = 16;
`ifdef MM_SCHED_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_async_i;
  logic       job_valid_i;
  logic       job_ready_o;
  logic [4:0] job_k_tiles_i;
  logic [4:0] job_n_tiles_i;
  logic [7:0] job_i_rows_i;
  logic [7:0] job_w_base_i;
  logic [7:0] job_i_base_i;
  logic [7:0] job_o_base_i;
  logic       abort_i;
  logic       mm_start_o;
  logic       mm_done_i;
  logic [7:0] mm_w_offset_o;
  logic [7:0] mm_i_offset_o;
  logic [7:0] mm_psum_offset_o;
  logic [7:0] mm_o_offset_o;
  logic [7:0] mm_i_rows_o;
  logic       mm_accum_en_o;
  logic       busy_o;
  logic       job_done_o;
  logic       err_o;

  int n_checks = 0;
  int n_errors = 0;

  mm_tile_scheduler #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i            (clk_i),
    .rst_async_i      (rst_async_i),
    .job_valid_i      (job_valid_i),
    .job_ready_o      (job_ready_o),
    .job_k_tiles_i    (job_k_tiles_i),
    .job_n_tiles_i    (job_n_tiles_i),
    .job_i_rows_i     (job_i_rows_i),
    .job_w_base_i     (job_w_base_i),
    .job_i_base_i     (job_i_base_i),
    .job_o_base_i     (job_o_base_i),
    .abort_i          (abort_i),
    .mm_start_o       (mm_start_o),
    .mm_done_i        (mm_done_i),
    .mm_w_offset_o    (mm_w_offset_o),
    .mm_i_offset_o    (mm_i_offset_o),
    .mm_psum_offset_o (mm_psum_offset_o),
    .mm_o_offset_o    (mm_o_offset_o),
    .mm_i_rows_o      (mm_i_rows_o),
    .mm_accum_en_o    (mm_accum_en_o),
    .busy_o           (busy_o),
    .job_done_o       (job_done_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one job. abort_mode: 0 none, 1 abort in WAIT of abort_tile, 2 abort in its ISSUE.
  task automatic run_job(input int kt, input int nt, input int rows, input int wb,
                         input int ib, input int ob, input int dly, input int abort_tile,
                         input int abort_mode, input bit stale);
    bit valid;
    int ntiles, tile, cd, exp_start, exp_done, c, budget;
    int ew, ei, eo, ea;
    bit exp_err, fin;
    valid  = (kt >= 1) && (kt <= 16) && (nt >= 1) && (nt <= 16);
    ntiles = valid ? kt * nt : 0;
    budget = ntiles * (dly + 3) + TMO + 10;

    @(negedge clk_i);
    check_eq("ready_before_job", job_ready_o, 1);
    job_k_tiles_i = 5'(kt);
    job_n_tiles_i = 5'(nt);
    job_i_rows_i  = 8'(rows);
    job_w_base_i  = 8'(wb);
    job_i_base_i  = 8'(ib);
    job_o_base_i  = 8'(ob);
    job_valid_i   = 1'b1;
    abort_i       = 1'b0;
    mm_done_i     = stale;

    exp_start = valid ? 1 : -1;
    exp_done  = valid ? -1 : 1;
    exp_err   = !valid;
    tile = 0;
    cd   = -1;
    ew = 0; ei = 0; eo = 0; ea = 0;
    c    = 0;
    fin  = 1'b0;
    while (!fin && c < budget) begin
      @(negedge clk_i);
      c++;
      job_valid_i = 1'b0;
      abort_i     = 1'b0;
      mm_done_i   = stale && (c + 1 == exp_start || c == exp_start);
      if (c == 1) check_eq("err_after_accept", err_o, int'(!valid));
      check_eq("busy", busy_o, 1);
      check_eq("start", mm_start_o, int'(c == exp_start));
      check_eq("job_done", job_done_o, int'(c == exp_done));
      if (c == exp_done) begin
        check_eq("err_at_done", err_o, int'(exp_err));
        fin = 1'b1;
      end else if (mm_start_o && c == exp_start) begin
        ew = (wb + ((tile / kt) * kt + (tile % kt)) * ROW) % DEPTH;
        ei = (ib + (tile % kt) * rows) % DEPTH;
        eo = (ob + (tile / kt) * rows) % DEPTH;
        ea = int'((tile % kt) != 0);
        check_eq("w_offset", mm_w_offset_o, ew);
        check_eq("i_offset", mm_i_offset_o, ei);
        check_eq("o_offset", mm_o_offset_o, eo);
        check_eq("psum_offset", mm_psum_offset_o, eo);
        check_eq("accum_en", mm_accum_en_o, ea);
        check_eq("i_rows", mm_i_rows_o, rows % DEPTH);
        if (abort_mode == 2 && tile == abort_tile) begin
          abort_i  = 1'b1;
          exp_done = c + 1;
          exp_err  = 1'b1;
        end else if (TmoEn && dly > int'(TMO)) begin
          exp_done = c + TMO + 1;
          exp_err  = 1'b1;
        end else begin
          cd = dly;
        end
      end else if (cd > 0) begin
        check_eq("w_hold", mm_w_offset_o, ew);
        check_eq("o_hold", mm_o_offset_o, eo);
        cd--;
        if (cd == 0) begin
          cd = -1;
          if (abort_mode == 1 && tile == abort_tile) begin
            abort_i   = 1'b1;
            mm_done_i = 1'($urandom_range(0, 1));
            exp_done  = c + 1;
            exp_err   = 1'b1;
          end else begin
            mm_done_i = 1'b1;
            tile++;
            if (tile == ntiles) exp_done = c + 2;
            else exp_start = c + 2;
          end
        end
      end
    end
    mm_done_i = 1'b0;
    abort_i   = 1'b0;
    check_eq("job_finished", int'(fin), 1);
  endtask

  task automatic reset_mid_job();
    int c;
    @(negedge clk_i);
    job_k_tiles_i = 5'd2;
    job_n_tiles_i = 5'd2;
    job_i_rows_i  = 8'd9;
    job_w_base_i  = 8'd100;
    job_i_base_i  = 8'd3;
    job_o_base_i  = 8'd77;
    job_valid_i   = 1'b1;
    c = 0;
    do begin
      @(negedge clk_i);
      job_valid_i = 1'b0;
      c++;
    end while (!mm_start_o && c < 5);
    check_eq("rst_test_start", mm_start_o, 1);
    @(negedge clk_i);
    check_eq("rst_test_busy_wait", busy_o, 1);
    #3 rst_async_i = 1'b1;
    #1;
    check_eq("rst_async_busy", busy_o, 0);
    check_eq("rst_async_ready", job_ready_o, 1);
    check_eq("rst_async_w", mm_w_offset_o, 0);
    check_eq("rst_async_o", mm_o_offset_o, 0);
    check_eq("rst_async_rows", mm_i_rows_o, 0);
    @(negedge clk_i);
    rst_async_i = 1'b0;
  endtask

  initial begin
    int kt, nt, r, dly, am, at;
    rst_async_i   = 1'b1;
    job_valid_i   = 1'b0;
    job_k_tiles_i = '0;
    job_n_tiles_i = '0;
    job_i_rows_i  = '0;
    job_w_base_i  = '0;
    job_i_base_i  = '0;
    job_o_base_i  = '0;
    abort_i       = 1'b0;
    mm_done_i     = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("reset_ready", job_ready_o, 1);
    check_eq("reset_busy", busy_o, 0);
    check_eq("reset_start", mm_start_o, 0);
    check_eq("reset_job_done", job_done_o, 0);
    check_eq("reset_err", err_o, 0);
    check_eq("reset_w", mm_w_offset_o, 0);
    check_eq("reset_accum", mm_accum_en_o, 0);
    rst_async_i = 1'b0;

    run_job(2, 2, 8, 0, 0, 16, 5, -1, 0, 1'b0);    // basic 2x2
    run_job(0, 3, 8, 0, 0, 0, 3, -1, 0, 1'b0);     // zero K
    run_job(1, 2, 8, 252, 0, 250, 3, -1, 0, 1'b0); // wrap, also clears err
    run_job(2, 2, 8, 10, 20, 30, 4, 1, 1, 1'b0);   // abort in WAIT of tile 2 of 4
    run_job(2, 2, 5, 1, 2, 3, 2, 0, 2, 1'b0);      // abort in ISSUE
    run_job(3, 2, 7, 40, 9, 60, 3, -1, 0, 1'b1);   // stale done through ISSUE
    run_job(17, 1, 4, 0, 0, 0, 2, -1, 0, 1'b0);    // K above MAX_TILES
    run_job(16, 1, 3, 200, 1, 2, 1, -1, 0, 1'b0);  // K at MAX_TILES
    reset_mid_job();
`ifdef MM_SCHED_TIMEOUT_EN
    run_job(1, 1, 8, 0, 0, 0, 100, -1, 0, 1'b0);   // done never returned
    run_job(1, 1, 8, 0, 0, 0, 16, -1, 0, 1'b0);    // done on the timeout cycle wins
`endif
    for (int j = 0; j < 30; j++) begin
      r  = int'($urandom_range(0, 11));
      kt = (r == 0) ? 0 : (r == 1) ? 17 : int'($urandom_range(1, 4));
      r  = int'($urandom_range(0, 11));
      nt = (r == 0) ? 0 : (r == 1) ? 17 : int'($urandom_range(1, 4));
      dly = int'($urandom_range(1, 6));
      am  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      at  = (kt >= 1 && kt <= 16 && nt >= 1 && nt <= 16) ?
            int'($urandom_range(0, kt * nt - 1)) : 0;
      run_job(kt, nt, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), dly, at, am,
              1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
